// File: rtl/program_loader_if.sv
// Host/RAM-side signal bundle for program_loader.
// slave  : the loader (consumes host pins, drives RAM write port and status).
// master : the host/environment side.
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  prog_mode;
  logic                  strobe;
  logic [3:0]            nibble_in;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_data;
  logic                  ram_we;
  logic                  hold_n;
  logic                  ack;
  logic                  done;
  logic [7:0]            checksum;

  modport slave (
    input  prog_mode, strobe, nibble_in,
    output ram_addr, ram_data, ram_we, hold_n, ack, done, checksum
  );

  modport master (
    output prog_mode, strobe, nibble_in,
    input  ram_addr, ram_data, ram_we, hold_n, ack, done, checksum
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: fills the program RAM from host pins, one byte per
// high/low nibble pair, holding the CPU for the whole session.
// Optional feature macro: LOADER_CHECKSUM_EN (running byte sum on checksum).
module program_loader #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  program_loader_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HI    = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [SYNC_STAGES-1:0] pm_sync_q, pm_sync_d;
  logic [SYNC_STAGES-1:0] st_sync_q, st_sync_d;
  logic                   pm_prev_q, pm_prev_d;
  logic                   st_prev_q, st_prev_d;
  logic                   pm_s, st_s;
  logic                   pm_rise, pm_fall, st_rise;

  logic [2:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [7:0]             data_q, data_d;
  logic                   ack_q, ack_d;
  logic                   done_q, done_d;

  // Synchroniser shift and edge detection against the previous synced value
  always_comb begin
    pm_sync_d = {pm_sync_q[SYNC_STAGES-2:0], bus.prog_mode};
    st_sync_d = {st_sync_q[SYNC_STAGES-2:0], bus.strobe};
    pm_s      = pm_sync_q[SYNC_STAGES-1];
    st_s      = st_sync_q[SYNC_STAGES-1];
    pm_prev_d = pm_s;
    st_prev_d = st_s;
    pm_rise   = pm_s & ~pm_prev_q;
    pm_fall   = ~pm_s & pm_prev_q;
    st_rise   = st_s & ~st_prev_q;
  end

  // Synchroniser and edge-detect registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_sync_q <= '0;
      st_sync_q <= '0;
      pm_prev_q <= 1'b0;
      st_prev_q <= 1'b0;
    end else begin
      pm_sync_q <= pm_sync_d;
      st_sync_q <= st_sync_d;
      pm_prev_q <= pm_prev_d;
      st_prev_q <= st_prev_d;
    end
  end

  // Load FSM: session start, nibble capture, write, completion and abort
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ack_d   = ack_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (pm_rise) begin
          state_d = S_HI;
          addr_d  = '0;
          done_d  = 1'b0;
        end
      end
      S_HI: begin
        // mode fall wins over a strobe edge seen on the same clock
        if (pm_fall) begin
          state_d = S_IDLE;
        end else if (st_rise) begin
          data_d[7:4] = bus.nibble_in;
          ack_d       = ~ack_q;
          state_d     = S_LO;
        end
      end
      S_LO: begin
        if (pm_fall) begin
          state_d = S_IDLE;
        end else if (st_rise) begin
          data_d[3:0] = bus.nibble_in;
          ack_d       = ~ack_q;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        if (pm_fall) begin
          state_d = S_IDLE;
        end else if (addr_q == '1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = S_HI;
        end
      end
      S_DONE: begin
        if (pm_fall) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  // Running sum of bytes written this session, cleared at session start
  always_comb begin
    csum_d = csum_q;
    if (state_q == S_IDLE && pm_rise) begin
      csum_d = '0;
    end else if (state_q == S_WRITE) begin
      csum_d = csum_q + data_q;
    end
  end

  // Checksum register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign bus.checksum = csum_q;
`else
  assign bus.checksum = '0;
`endif

  assign bus.ram_addr = addr_q;
  assign bus.ram_data = data_q;
  assign bus.ram_we   = (state_q == S_WRITE);
  assign bus.hold_n   = (state_q == S_IDLE);
  assign bus.ack      = ack_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected RAM writes,
// an independent monitor pops and compares on every ram_we pulse.
module tb_program_loader;
  localparam int unsigned AW = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned NBYTES = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  wr_t  exp_q[$];

  // behavioural session model
  int   m_count;
  bit   m_done;
  int   m_sum;
  logic [7:0] m_last;

  program_loader_if #(.ADDR_WIDTH(AW)) bus ();

  program_loader #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_csum();
`ifdef LOADER_CHECKSUM_EN
    return 8'(m_sum);
`else
    return 8'h00;
`endif
  endfunction

  // monitor: every write pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && bus.ram_we) begin
      wr_t w;
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 32'(bus.ram_addr), 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        chk("we_addr", 32'(bus.ram_addr), 32'(w.addr));
        chk("we_data", 32'(bus.ram_data), 32'(w.data));
        chk("we_hold_n", 32'(bus.hold_n), 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // drive one nibble; wait (bounded) for the ack toggle when one is expected
  task automatic send_nibble(input logic [3:0] n, input bit expect_ack, input bit is_lo);
    logic a0;
    int   lat;
    a0 = bus.ack;
    lat = 0;
    bus.nibble_in = n;
    bus.strobe = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.ack !== a0) begin
        lat = i;
        if (is_lo && expect_ack) chk("we_after_lo", 32'(bus.ram_we), 32'd1);
        break;
      end
    end
    bus.strobe = 1'b0;
    if (expect_ack) chk("ack_latency", 32'(lat), 32'(SS + 1));
    else            chk("ack_hold", 32'(bus.ack), 32'(a0));
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    acc = !m_done;
    if (acc) exp_q.push_back('{addr: AW'(m_count), data: b});
    send_nibble(b[7:4], acc, 1'b0);
    send_nibble(b[3:0], acc, 1'b1);
    if (acc) begin
      m_sum  = (m_sum + int'(b)) % 256;
      m_last = b;
      m_count++;
      if (m_count == NBYTES) m_done = 1'b1;
    end
  endtask

  task automatic start_session();
    bus.prog_mode = 1'b1;
    tick(5);
    m_count = 0;
    m_done  = 1'b0;
    m_sum   = 0;
    chk("start_hold_n", 32'(bus.hold_n), 32'd0);
    chk("start_addr", 32'(bus.ram_addr), 32'd0);
    chk("start_done", 32'(bus.done), 32'd0);
    chk("start_csum", 32'(bus.checksum), 32'd0);
  endtask

  task automatic end_session();
    int ea;
    bus.prog_mode = 1'b0;
    tick(SS + 2);
    ea = m_done ? NBYTES - 1 : m_count;
    chk("end_hold_n", 32'(bus.hold_n), 32'd1);
    chk("end_addr", 32'(bus.ram_addr), 32'(ea));
    chk("end_done", 32'(bus.done), 32'(m_done));
    chk("end_csum", 32'(bus.checksum), 32'(exp_csum()));
    tick(2);
  endtask

  initial begin
    logic a0;
    checks = 0;
    errors = 0;
    m_count = 0; m_done = 0; m_sum = 0; m_last = 8'h00;
    rst_n = 1'b0;
    bus.prog_mode = 1'b0;
    bus.strobe = 1'b0;
    bus.nibble_in = 4'h0;
    #12;
    chk("rst_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_data", 32'(bus.ram_data), 32'd0);
    chk("rst_we", 32'(bus.ram_we), 32'd0);
    chk("rst_hold_n", 32'(bus.hold_n), 32'd1);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_csum", 32'(bus.checksum), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(3);

    // full load of 0x10..0x1F, then overrun strobes in DONE
    start_session();
    for (int i = 0; i < int'(NBYTES); i++) send_byte(8'(8'h10 + i));
    chk("full_done", 32'(bus.done), 32'd1);
    chk("full_hold_n", 32'(bus.hold_n), 32'd0);
    chk("full_csum", 32'(bus.checksum), 32'(exp_csum()));
`ifdef LOADER_CHECKSUM_EN
    chk("full_csum_abs", 32'(bus.checksum), 32'h78);
`endif
    a0 = bus.ack;
    send_nibble(4'h3, 1'b0, 1'b0);
    send_nibble(4'hC, 1'b0, 1'b1);
    chk("overrun_ack", 32'(bus.ack), 32'(a0));
    chk("overrun_addr", 32'(bus.ram_addr), 32'(NBYTES - 1));
    end_session();
    start_session();
    end_session();

    // abort after a lone high nibble 0xA
    start_session();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    send_nibble(4'hA, 1'b1, 1'b0);
    end_session();

    // prog_mode fall and strobe rise arrive together: no capture
    start_session();
    send_byte(8'($urandom));
    a0 = bus.ack;
    bus.nibble_in = 4'h5;
    bus.strobe = 1'b1;
    bus.prog_mode = 1'b0;
    tick(8);
    chk("simul_ack", 32'(bus.ack), 32'(a0));
    chk("simul_hold_n", 32'(bus.hold_n), 32'd1);
    chk("simul_addr", 32'(bus.ram_addr), 32'd1);
    chk("simul_data", 32'(bus.ram_data), 32'(m_last));
    bus.strobe = 1'b0;
    tick(4);

    // randomized sessions, some ending with a dangling high nibble
    for (int s = 0; s < 4; s++) begin
      int nb;
      start_session();
      nb = $urandom_range(1, 18);
      for (int i = 0; i < nb; i++) send_byte(8'($urandom));
      if ($urandom_range(0, 1) == 1) send_nibble(4'($urandom), !m_done, 1'b0);
      end_session();
    end

    // asynchronous reset while waiting for the low nibble
    start_session();
    send_byte(8'($urandom));
    send_nibble(4'h7, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    bus.prog_mode = 1'b0;
    #1;
    chk("arst_addr", 32'(bus.ram_addr), 32'd0);
    chk("arst_data", 32'(bus.ram_data), 32'd0);
    chk("arst_we", 32'(bus.ram_we), 32'd0);
    chk("arst_hold_n", 32'(bus.hold_n), 32'd1);
    chk("arst_ack", 32'(bus.ack), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_csum", 32'(bus.checksum), 32'd0);
    tick(2);
    rst_n = 1'b1;
    chk("arst_rel_hold_n", 32'(bus.hold_n), 32'd1);
    tick(6);
    chk("arst_idle_hold_n", 32'(bus.hold_n), 32'd1);
    chk("arst_idle_ack", 32'(bus.ack), 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
